chebyshev_expand_stream: RTL



---
 rtl/chebyshev_expand_stream.sv | 139 +++++++++++++
 1 files changed

// File: rtl/chebyshev_expand_stream.sv
// chebyshev_expand_stream
//   Purpose : re-expands saturated narrow Chebyshev words (BOUNDARY_BIT_POSITION
//             integer bits) to the full WL/I_BITS format by sign extension, and
//             flags samples that sit on either saturation rail.
//   Latency : a word accepted at edge N is on out_* after edge N (1 cycle).
//   Backpressure: main register plus one skid register. in_ready is the skid's
//             "empty" state (registered, no combinational path from out_ready).
//   Ports   : clk/rst (async, active-high), in_valid/in_ready/in_data/in_last
//             upstream, out_valid/out_ready/out_data/out_rail/out_last
//             downstream, rail_count = rail samples in the current frame.
//   Optional: define CHEB_EXPAND_RAIL_CNT_EN to build the per-frame rail
//             counter. Without it, rail_count is tied to zero.
module chebyshev_expand_stream #(
    parameter int WL                    = 12,
    parameter int I_BITS                = 6,
    parameter int BOUNDARY_BIT_POSITION = 3,
    parameter int O_BITS                = WL - (I_BITS - BOUNDARY_BIT_POSITION),
    parameter int CNT_W                 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [O_BITS-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WL-1:0]     out_data,
    output logic              out_rail,
    output logic              out_last,
    output logic [CNT_W-1:0]  rail_count
);

    localparam int EXT = I_BITS - BOUNDARY_BIT_POSITION;

    logic [WL-1:0] in_ext;
    logic          in_rail;
    logic          in_fire;
    logic          main_free;

    // Skid register: only ever occupied while the main register is stalled.
    logic          s_vld;
    logic [WL-1:0] s_dat;
    logic          s_rail;
    logic          s_last;

    assign in_ext  = {{EXT{in_data[O_BITS-1]}}, in_data};
    assign in_rail = (in_data == {1'b0, {(O_BITS-1){1'b1}}}) ||
                     (in_data == {1'b1, {(O_BITS-1){1'b0}}});

    assign in_ready  = ~s_vld;
    assign in_fire   = in_valid && in_ready;
    // Main can take a new entry this edge if it is empty or its word leaves now.
    assign main_free = ~out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rail  <= 1'b0;
            out_last  <= 1'b0;
            s_vld     <= 1'b0;
            s_dat     <= '0;
            s_rail    <= 1'b0;
            s_last    <= 1'b0;
        end else begin
            if (main_free) begin
                // s_vld implies in_ready=0, so skid drain and input load never collide.
                if (s_vld) begin
                    out_valid <= 1'b1;
                    out_data  <= s_dat;
                    out_rail  <= s_rail;
                    out_last  <= s_last;
                    s_vld     <= 1'b0;
                end else if (in_fire) begin
                    out_valid <= 1'b1;
                    out_data  <= in_ext;
                    out_rail  <= in_rail;
                    out_last  <= in_last;
                end else begin
                    // Payload holds its last value; only the valid flag drops.
                    out_valid <= 1'b0;
                end
            end else if (in_fire) begin
                s_vld  <= 1'b1;
                s_dat  <= in_ext;
                s_rail <= in_rail;
                s_last <= in_last;
            end
        end
    end

`ifdef CHEB_EXPAND_RAIL_CNT_EN
    // Each entry carries a snapshot of the running frame count taken at
    // acceptance (including itself), so the value on the out_last beat is the
    // frame total regardless of how long the word sat in the buffer.
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] s_cnt;
    logic [CNT_W-1:0] m_cnt;

    always_comb begin
        in_cnt = acc;
        if (in_rail && (acc != {CNT_W{1'b1}})) begin
            in_cnt = acc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            s_cnt <= '0;
            m_cnt <= '0;
        end else begin
            if (in_fire) begin
                // The first word of the next frame starts counting from zero.
                acc <= in_last ? '0 : in_cnt;
            end
            if (main_free) begin
                if (s_vld) begin
                    m_cnt <= s_cnt;
                end else if (in_fire) begin
                    m_cnt <= in_cnt;
                end else if (out_last) begin
                    // The frame just closed and nothing replaces it: show a cleared count.
                    m_cnt <= '0;
                end
            end else if (in_fire) begin
                s_cnt <= in_cnt;
            end
        end
    end

    assign rail_count = m_cnt;
`else
    assign rail_count = '0;
`endif

endmodule
